// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with configurable payload width, parity and stop
// bits, and a one-word holding register with a valid/ready handshake.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3
// vote around mid-bit. The vote completes one clock later than the
// single-sample decision.
module uart_rx_ext #(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    input  logic                 rx_data_ready,
    output logic                 rx_data_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int CNT_MAX = CLK_FRE / BAUD_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int HALF    = CNT_MAX / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_AT = HALF + 1;
`else
    localparam int SAMPLE_AT = HALF;
`endif
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CNT_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam bit               PAR_EN     = (PARITY != 0);
    localparam bit               TWO_STOP   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state, next_state;
    logic                 rx_q1, rx_q2, rx_q3;
    logic                 rx_fall;
    logic                 bit_val;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 stop_last;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 par_exp;
    logic                 ferr_cap;
    logic                 sample_tick;
    logic                 bit_end;
    logic                 frame_done;

    // Synchronize the asynchronous line and keep one extra stage for edge detection.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q1 <= 1'b1;
            rx_q2 <= 1'b1;
            rx_q3 <= 1'b1;
        end else begin
            rx_q1 <= rx_pin;
            rx_q2 <= rx_q1;
            rx_q3 <= rx_q2;
        end
    end

    assign rx_fall = rx_q3 & ~rx_q2;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    // Keep the two previous synchronized samples so the vote sees three consecutive clocks.
    always_ff @(posedge clk) begin
        if (rst) rx_hist <= 2'b11;
        else     rx_hist <= {rx_hist[0], rx_q2};
    end

    assign bit_val = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_q2) | (rx_hist[0] & rx_q2);
`else
    assign bit_val = rx_q2;
`endif

    assign sample_tick = (cnt == SAMPLE_CNT);
    assign bit_end     = (cnt == CNT_LAST);
    assign stop_last   = TWO_STOP ? stop_idx : 1'b1;
    assign par_exp     = (PARITY == 1) ? ~(^shift) : (^shift);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode; frame_done marks the final stop-bit decision.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (rx_fall) next_state = START;
            START: begin
                if (sample_tick && bit_val) next_state = IDLE;
                else if (bit_end)           next_state = DATA;
            end
            DATA:  if (bit_end && bit_idx == IDX_LAST) next_state = PAR_EN ? PAR : STOP;
            PAR:   if (bit_end) next_state = STOP;
            STOP: begin
                if (sample_tick && stop_last) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timing, bit position tracking and capture of data, parity and stop samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            ferr_cap <= 1'b0;
        end else begin
            if (state == IDLE || next_state == IDLE) cnt <= '0;
            else if (bit_end)                         cnt <= '0;
            else                                      cnt <= cnt + CNT_W'(1);

            if (state != DATA)  bit_idx <= '0;
            else if (bit_end)   bit_idx <= bit_idx + IDX_W'(1);

            if (state != STOP)  stop_idx <= 1'b0;
            else if (bit_end)   stop_idx <= 1'b1;

            if (state == DATA && sample_tick) shift[bit_idx] <= bit_val;
            if (state == PAR && sample_tick)  par_bit <= bit_val;

            if (state == IDLE)                            ferr_cap <= 1'b0;
            else if (state == STOP && sample_tick && !bit_val) ferr_cap <= 1'b1;
        end
    end

    // Holding register: load on a completed frame unless an unread word would be overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_valid <= 1'b0;
            rx_data       <= '0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data_valid <= 1'b1;
                    rx_data       <= shift;
                    parity_err    <= PAR_EN && (par_bit != par_exp);
                    frame_err     <= ferr_cap | ~bit_val;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, payload bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, where 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic rises on posedge clk.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port rx_pin, input, 1 bit, asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data_ready, input, 1 bit, consumer accepts the held word.
REQ-010 SHALL have port rx_data_valid, output, 1 bit, rx_data and the error flags are valid.
REQ-011 SHALL have port rx_data, output, DATA_BITS bits, received payload, LSB first on the line.
REQ-012 SHALL have port parity_err, output, 1 bit, parity mismatch on the held word.
REQ-013 SHALL have port frame_err, output, 1 bit, some stop bit sampled low on the held word.
REQ-014 SHALL have port overrun_err, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass rx_pin through a 2-flop synchronizer (both flops reset to 1); all decoding uses the synchronized line.
REQ-016 SHALL define CNT_MAX = CLK_FRE/BAUD_RATE clocks per bit; the bit counter runs 0..CNT_MAX-1 and wraps to 0.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
- IDLE -> START on a synchronized falling edge; the counter clears.
REQ-018 In START, SHALL sample at count CNT_MAX/2.
- Line high: false start, return to IDLE.
- Line low: go to DATA.
REQ-019 SHALL sample each data bit at mid-bit (count CNT_MAX/2) into bit index 0..DATA_BITS-1, LSB first.
REQ-020 After the last data bit, SHALL go to PAR if PARITY != 0, else to STOP.
REQ-021 SHALL compute parity as the XOR of the data bits; the expected parity bit is ~XOR when PARITY = 1 and XOR when PARITY = 2.
REQ-022 In STOP, SHALL sample STOP_BITS bits; any low sample sets the frame-error capture.
- Frame completes at the mid-sample of the final stop bit; FSM returns to IDLE on that cycle.
REQ-023 Frame-complete with rx_data_valid low or rx_data_ready high:
- Load rx_data, parity_err, frame_err.
- Assert rx_data_valid on the next cycle (latency: 1 clk after the final stop sample).
REQ-024 Frame-complete with rx_data_valid high and rx_data_ready low:
- Drop the new frame.
- Pulse overrun_err high for one cycle.
- Hold rx_data and the flags unchanged.
REQ-025 Handshake:
- rx_data_valid stays high until the cycle in which rx_data_ready is high; it clears on the next edge unless REQ-023 reloads it on that same edge (back-to-back).
- rx_data_ready while rx_data_valid is low has no effect.
REQ-026 SHALL keep receiving new frames while a word is held; reception does not wait for rx_data_ready.
REQ-027 Unused encodings: SHALL go to IDLE, and SHALL go to IDLE on the next cycle from any illegal state encoding.

Reset
REQ-028 On rst high at a clk edge: FSM = IDLE, counters = 0, rx_data = 0, rx_data_valid = parity_err = frame_err = overrun_err = 0, synchronizer flops = 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no valid and no error output; the next falling edge after reset release starts a fresh frame.

Configuration
REQ-030 With macro UART_RX_MAJORITY_EN defined:
- Each start, data, parity and stop decision is the 2-of-3 majority of samples at counts CNT_MAX/2-1, CNT_MAX/2 and CNT_MAX/2+1.
- The decision is made at CNT_MAX/2+1, so all completion timing shifts 1 clk later.
REQ-031 Without UART_RX_MAJORITY_EN, SHALL use the single sample at count CNT_MAX/2, with no voting logic synthesized.

Verification (CLK_FRE = 50 MHz, BAUD_RATE = 115200, CNT_MAX = 434)
REQ-032 Defaults, send 0xA5 -> rx_data = 0xA5 and rx_data_valid high 1 clk after the stop mid-sample; parity_err = frame_err = 0.
REQ-033 PARITY = 2, send 0x07 with parity bit 0 -> rx_data = 0x07 and parity_err = 1; resend with parity bit 1 -> parity_err = 0.
REQ-034 Send 0x3C with stop bit driven low -> frame_err = 1 and rx_data = 0x3C.
REQ-035 Hold rx_data_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun_err pulses once; raise ready -> valid clears.
REQ-036 A 100-clk low glitch on an idle line -> no valid output, FSM back in IDLE; a 0x55 sent next is received correctly.
REQ-037 Assert rst during data bit 3 -> all outputs 0; a following 0x81 is received correctly; with UART_RX_MAJORITY_EN, a 1-clk inverted glitch at mid-bit is ignored.
